wsi_pattern_gen_worker: RTL and testbench

- Upstream stimulus worker that produces WSI messages to feed a delay/bias-class worker's WSI slave port.
- Software configures it over WCI slave 0 (message length, count, seed, opcode) and starts it with a control op.
- It then emits precise bursts of an incrementing data pattern on WSI master 0 and honours SThreadBusy backpressure.
- It keeps counters of words and messages sent for bring-up and for checking the downstream worker.

---
 rtl/wsi_pattern_gen_worker_if.sv | 77 +++++++
 rtl/wsi_pattern_gen_worker.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_wsi_pattern_gen_worker.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wsi_pattern_gen_worker_if.sv
// ----------------------------------------------------------------------------
// Bus interfaces for wsi_pattern_gen_worker.
//
// wci_if : WCI control/configuration bus.
//   master modport = host side (drives M* request fields, receives S* fields)
//   slave  modport = worker side
//   MCmd[2:0]       request command (001 write, 010 read, else idle)
//   MAddrSpace      0 = control-op space, 1 = config property space
//   MByteEn[3:0]    write byte enables
//   MAddr[31:0]     byte address
//   MData[31:0]     write data
//   MFlag[1:0]      host flags (not used by this worker)
//   SResp[1:0]      01 = DVA, 00 = no response
//   SData[31:0]     read data, valid with DVA
//   SThreadBusy     high while the worker is held in reset
//   SFlag[1:0]      worker flags (always 0)
//
// wsi_if : WSI streaming bus, parameterised by the data width W.
//   master modport = message producer, slave modport = message consumer
//   MCmd[2:0]       001 = WR, 000 = idle
//   MReqLast        last word of the message
//   MBurstPrecise   burst length is exact
//   MBurstLength    words in the current message
//   MData[W-1:0]    payload
//   MByteEn[W/8-1:0] payload byte enables
//   MReqInfo[7:0]   opcode
//   MReset_n        producer reset, active low
//   SThreadBusy     consumer cannot accept a word
//   SReset_n        consumer reset, active low
// ----------------------------------------------------------------------------
interface wci_if;
    logic [2:0]  MCmd;
    logic        MAddrSpace;
    logic [3:0]  MByteEn;
    logic [31:0] MAddr;
    logic [31:0] MData;
    logic [1:0]  MFlag;
    logic [1:0]  SResp;
    logic [31:0] SData;
    logic        SThreadBusy;
    logic [1:0]  SFlag;

    modport master (
        output MCmd, MAddrSpace, MByteEn, MAddr, MData, MFlag,
        input  SResp, SData, SThreadBusy, SFlag
    );
    modport slave (
        input  MCmd, MAddrSpace, MByteEn, MAddr, MData, MFlag,
        output SResp, SData, SThreadBusy, SFlag
    );
endinterface

interface wsi_if #(
    parameter int W = 32
);
    logic [2:0]     MCmd;
    logic           MReqLast;
    logic           MBurstPrecise;
    logic [11:0]    MBurstLength;
    logic [W-1:0]   MData;
    logic [W/8-1:0] MByteEn;
    logic [7:0]     MReqInfo;
    logic           MReset_n;
    logic           SThreadBusy;
    logic           SReset_n;

    modport master (
        output MCmd, MReqLast, MBurstPrecise, MBurstLength, MData, MByteEn,
               MReqInfo, MReset_n,
        input  SThreadBusy, SReset_n
    );
    modport slave (
        input  MCmd, MReqLast, MBurstPrecise, MBurstLength, MData, MByteEn,
               MReqInfo, MReset_n,
        output SThreadBusy, SReset_n
    );
endinterface

// File: rtl/wsi_pattern_gen_worker.sv
// ----------------------------------------------------------------------------
// wsi_pattern_gen_worker
//
// Stimulus worker: software programs message length, message count, seed and
// opcode over WCI, starts it with a control op, and it then emits precise
// bursts of an incrementing 32-bit-lane pattern on its WSI master port while
// honouring SThreadBusy backpressure. Words and messages sent are counted.
//
// Ports:
//   wciS0_Clk       sole clock
//   wciS0_MReset_n  synchronous active-low reset
//   wciS0           WCI slave (control ops in space 0, properties in space 1)
//   wsiM0           WSI master (pattern output)
//
// Property map (space 1, byte address):
//   0x00 ctrl (bit0 = run)   0x04 msgLen[11:0]   0x08 msgCount (0 = infinite)
//   0x0C seed                0x10 opcode[7:0]
//   0x14 wordsSent (RO)      0x18 msgsSent (RO)  others read 0
// Control ops (space 0, MAddr[4:2]): 0 initialize, 1 start, 2 stop.
// ----------------------------------------------------------------------------
module wsi_pattern_gen_worker #(
    parameter int          WSI_M0_DATAPATH_WIDTH = 32,
    parameter logic [31:0] WORKER_CTRL_INIT      = 32'd0,
    parameter bit          HAS_DEBUG_LOGIC       = 1'b1
) (
    input  logic  wciS0_Clk,
    input  logic  wciS0_MReset_n,
    wci_if.slave  wciS0,
    wsi_if.master wsiM0
);
    localparam int W      = WSI_M0_DATAPATH_WIDTH;
    localparam int NLANES = W / 32;
    localparam int NBYTES = W / 8;

    generate
        if (W != 32 && W != 64 && W != 128 && W != 256) begin : g_bad_width
            $fatal(1, "wsi_pattern_gen_worker: unsupported WSI_M0_DATAPATH_WIDTH");
        end
    endgenerate

    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;
    localparam logic [1:0] RESP_DVA = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [31:0] r_ctrl;
    logic [11:0] r_msg_len;
    logic [31:0] r_msg_count;
    logic [31:0] r_seed;
    logic [7:0]  r_opcode;
    logic [31:0] r_words_sent;
    logic [31:0] r_msgs_sent;

    // Per-message state, latched when a message begins
    logic [11:0] r_word_idx;
    logic [11:0] r_cur_len;
    logic [7:0]  r_cur_op;
    logic [31:0] r_ctr;

    // WCI response registers
    logic [1:0]  r_sresp;
    logic [31:0] r_sdata;
    logic        r_sthreadbusy;

    // WSI output registers
    logic [2:0]        r_mcmd;
    logic              r_mreqlast;
    logic [11:0]       r_mburstlen;
    logic [W-1:0]      r_mdata;
    logic [NBYTES-1:0] r_mbyteen;
    logic [7:0]        r_mreqinfo;
    logic              r_mreset_n;

    // ------------------------------------------------------------------
    // WCI request decode
    // ------------------------------------------------------------------
    logic        w_req_wr;
    logic        w_req_rd;
    logic        w_req;
    logic        w_ctl;
    logic        w_op_init;
    logic        w_op_start;
    logic        w_op_stop;
    logic        w_cfg_hit;
    logic        w_cfg_wr;
    logic [2:0]  w_sel;
    logic [31:0] w_rdata;
    logic [31:0] w_merged;
    logic [31:0] w_ctrl_next;

    assign w_req_wr   = (wciS0.MCmd == CMD_WR);
    assign w_req_rd   = (wciS0.MCmd == CMD_RD);
    assign w_req      = w_req_wr || w_req_rd;
    assign w_sel      = wciS0.MAddr[4:2];

    // Control ops are accepted on either command type in space 0.
    assign w_ctl      = w_req && !wciS0.MAddrSpace;
    assign w_op_init  = w_ctl && (w_sel == 3'd0);
    assign w_op_start = w_ctl && (w_sel == 3'd1);
    assign w_op_stop  = w_ctl && (w_sel == 3'd2);

    // Properties live in the first 32 bytes; anything above is unmapped.
    assign w_cfg_hit  = wciS0.MAddrSpace && (wciS0.MAddr[31:5] == 27'd0);
    assign w_cfg_wr   = w_req_wr && w_cfg_hit;

    // Current value of the addressed property; also the base for masked writes.
    always_comb begin
        w_rdata = 32'd0;
        if (w_cfg_hit) begin
            case (w_sel)
                3'd0:    w_rdata = r_ctrl;
                3'd1:    w_rdata = {20'd0, r_msg_len};
                3'd2:    w_rdata = r_msg_count;
                3'd3:    w_rdata = r_seed;
                3'd4:    w_rdata = {24'd0, r_opcode};
                3'd5:    w_rdata = HAS_DEBUG_LOGIC ? r_words_sent : 32'd0;
                3'd6:    w_rdata = HAS_DEBUG_LOGIC ? r_msgs_sent : 32'd0;
                default: w_rdata = 32'd0;
            endcase
        end
    end

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

    assign w_merged = f_merge(w_rdata, wciS0.MData, wciS0.MByteEn);

    // Next ctrl value: property write, then start/stop ops (only one request
    // per cycle, so these never collide).
    always_comb begin
        w_ctrl_next = r_ctrl;
        if (w_cfg_wr && (w_sel == 3'd0)) begin
            w_ctrl_next = w_merged;
        end
        if (w_op_start) begin
            w_ctrl_next[0] = 1'b1;
        end
        if (w_op_stop) begin
            w_ctrl_next[0] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Issue datapath
    // ------------------------------------------------------------------
    logic [W-1:0] w_lane_data;
    logic         w_can_issue;
    logic         w_zlm;
    logic         w_last;
    logic [31:0]  w_words_base;
    logic [31:0]  w_msgs_base;
    logic [31:0]  w_msgs_inc;

    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : g_lane
            assign w_lane_data[gi*32 +: 32] = r_ctr + 32'(gi);
        end
    endgenerate

    // The word is decided at the same edge that captures busy_q, and is
    // registered onto the bus, so a word is on the bus in a cycle only when
    // busy_q (and the sampled downstream reset) allowed it for that cycle.
    assign w_can_issue  = !wsiM0.SThreadBusy && wsiM0.SReset_n;

    assign w_zlm        = (r_cur_len == 12'd0);
    assign w_last       = w_zlm || (r_word_idx == (r_cur_len - 12'd1));

    // Initialize clears the counters; an issue in the same cycle counts on top.
    assign w_words_base = w_op_init ? 32'd0 : r_words_sent;
    assign w_msgs_base  = w_op_init ? 32'd0 : r_msgs_sent;
    assign w_msgs_inc   = w_msgs_base + 32'd1;

    // ------------------------------------------------------------------
    // Configuration, WCI response and FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wciS0_Clk) begin
        if (!wciS0_MReset_n) begin
            r_state       <= ST_IDLE;
            r_ctrl        <= WORKER_CTRL_INIT;
            r_msg_len     <= 12'd0;
            r_msg_count   <= 32'd0;
            r_seed        <= 32'd0;
            r_opcode      <= 8'd0;
            r_words_sent  <= 32'd0;
            r_msgs_sent   <= 32'd0;
            r_word_idx    <= 12'd0;
            r_cur_len     <= 12'd0;
            r_cur_op      <= 8'd0;
            r_ctr         <= 32'd0;
            r_sresp       <= 2'b00;
            r_sdata       <= 32'd0;
            r_sthreadbusy <= 1'b1;
            r_mcmd        <= 3'b000;
            r_mreqlast    <= 1'b0;
            r_mburstlen   <= 12'd0;
            r_mdata       <= '0;
            r_mbyteen     <= '0;
            r_mreqinfo    <= 8'd0;
            r_mreset_n    <= 1'b0;
        end else begin
            r_mreset_n    <= 1'b1;
            r_sthreadbusy <= 1'b0;

            // One-cycle DVA for every accepted request; data only on property reads.
            r_sresp <= w_req ? RESP_DVA : 2'b00;
            r_sdata <= (w_req_rd && w_cfg_hit) ? w_rdata : 32'd0;

            r_ctrl <= w_ctrl_next;
            if (w_cfg_wr) begin
                case (w_sel)
                    3'd1:    r_msg_len   <= w_merged[11:0];
                    3'd2:    r_msg_count <= w_merged;
                    3'd3:    r_seed      <= w_merged;
                    3'd4:    r_opcode    <= w_merged[7:0];
                    default: ;
                endcase
            end

            r_words_sent <= w_words_base;
            r_msgs_sent  <= w_msgs_base;
            r_mcmd       <= 3'b000;
            r_mreqlast   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (r_ctrl[0] && ((r_msg_count == 32'd0) || (r_msgs_sent < r_msg_count))) begin
                        r_state    <= ST_RUN;
                        r_word_idx <= 12'd0;
                        r_ctr      <= r_seed;
                        r_cur_len  <= r_msg_len;
                        r_cur_op   <= r_opcode;
                    end
                end

                ST_RUN: begin
                    if (w_can_issue) begin
                        r_mcmd       <= CMD_WR;
                        r_mdata      <= w_lane_data;
                        r_mbyteen    <= w_zlm ? '0 : {NBYTES{1'b1}};
                        r_mburstlen  <= w_zlm ? 12'd1 : r_cur_len;
                        r_mreqlast   <= w_last;
                        r_mreqinfo   <= r_cur_op;
                        r_words_sent <= w_words_base + 32'd1;
                        // A zero-length message carries no payload, so the
                        // pattern does not advance for it.
                        if (!w_zlm) begin
                            r_ctr <= r_ctr + 32'(NLANES);
                        end
                        if (w_last) begin
                            r_msgs_sent <= w_msgs_inc;
                            // Back-to-back messages continue the pattern but
                            // pick up fresh length/opcode.
                            r_word_idx  <= 12'd0;
                            r_cur_len   <= r_msg_len;
                            r_cur_op    <= r_opcode;
                            if ((r_msg_count != 32'd0) && (w_msgs_inc >= r_msg_count)) begin
                                r_state <= ST_DONE;
                            end else if (!w_ctrl_next[0]) begin
                                // Stop takes effect only at a message boundary,
                                // including a stop arriving with the last word.
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_word_idx <= r_word_idx + 12'd1;
                        end
                    end
                end

                ST_DONE: begin
                    if (w_op_init) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wciS0.SResp         = r_sresp;
    assign wciS0.SData         = r_sdata;
    assign wciS0.SThreadBusy   = r_sthreadbusy;
    assign wciS0.SFlag         = 2'b00;

    assign wsiM0.MCmd          = r_mcmd;
    assign wsiM0.MReqLast      = r_mreqlast;
    assign wsiM0.MBurstPrecise = 1'b1;
    assign wsiM0.MBurstLength  = r_mburstlen;
    assign wsiM0.MData         = r_mdata;
    assign wsiM0.MByteEn       = r_mbyteen;
    assign wsiM0.MReqInfo      = r_mreqinfo;
    assign wsiM0.MReset_n      = r_mreset_n;

    // Request fields this worker deliberately ignores.
    logic w_unused;
    assign w_unused = ^{wciS0.MFlag, wciS0.MAddr[1:0]};

endmodule

// File: tb/tb_wsi_pattern_gen_worker.sv
module tb_wsi_pattern_gen_worker;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  be;
        logic         last;
        logic [11:0]  blen;
        logic [7:0]   info;
    } exp_word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy = 1'b0;
    logic sreset_n = 1'b1;
    logic busy_q = 1'b0;
    logic sreset_q = 1'b1;

    int checks = 0;
    int errors = 0;
    int nwords [2];

    exp_word_t wsi_q0 [$];
    exp_word_t wsi_q1 [$];
    logic [31:0] wci_q0 [$];
    logic [31:0] wci_q1 [$];
    bit pend0 = 1'b0;
    bit pend1 = 1'b0;

    always #5 clk = ~clk;

    wci_if u_wci32 ();
    wsi_if #(.W(32)) u_wsi32 ();
    wci_if u_wci128 ();
    wsi_if #(.W(128)) u_wsi128 ();

    assign u_wsi32.SThreadBusy  = busy;
    assign u_wsi32.SReset_n     = sreset_n;
    assign u_wsi128.SThreadBusy = busy;
    assign u_wsi128.SReset_n    = sreset_n;

    wsi_pattern_gen_worker #(.WSI_M0_DATAPATH_WIDTH(32)) u_dut32 (
        .wciS0_Clk      (clk),
        .wciS0_MReset_n (rst_n),
        .wciS0          (u_wci32),
        .wsiM0          (u_wsi32)
    );

    wsi_pattern_gen_worker #(.WSI_M0_DATAPATH_WIDTH(128)) u_dut128 (
        .wciS0_Clk      (clk),
        .wciS0_MReset_n (rst_n),
        .wciS0          (u_wci128),
        .wsiM0          (u_wsi128)
    );

    always @(posedge clk) begin
        busy_q   <= busy;
        sreset_q <= sreset_n;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // ---------------- scoreboard monitors ----------------
    task automatic wsi_check(input int sel, input logic [255:0] data, input logic [31:0] be,
                             input logic last, input logic [11:0] blen, input logic [7:0] info);
        exp_word_t e;
        nwords[sel]++;
        check("wsi_issue_allowed", {30'd0, busy_q, ~sreset_q}, 256'd0);
        if ((sel == 0 && wsi_q0.size() == 0) || (sel == 1 && wsi_q1.size() == 0)) begin
            fail_event("wsi_unexpected_word");
            return;
        end
        e = (sel == 0) ? wsi_q0.pop_front() : wsi_q1.pop_front();
        $display("WSI dut%0d word %0d data %0h be %0h last %0b blen %0d info %0h",
                 sel, nwords[sel], data, be, last, blen, info);
        check("wsi_data", data, e.data);
        check("wsi_byteen", {224'd0, be}, {224'd0, e.be});
        check("wsi_last", {255'd0, last}, {255'd0, e.last});
        check("wsi_blen", {244'd0, blen}, {244'd0, e.blen});
        check("wsi_info", {248'd0, info}, {248'd0, e.info});
    endtask

    task automatic wci_check(input int sel, input logic [1:0] sresp, input logic [31:0] sdata, input bit pend);
        logic [31:0] e;
        if (!pend && sresp == 2'b00) return;
        check("wci_dva_timing", {254'd0, sresp}, pend ? 256'd1 : 256'd0);
        if (pend && sresp == 2'b01) begin
            if ((sel == 0 && wci_q0.size() == 0) || (sel == 1 && wci_q1.size() == 0)) begin
                fail_event("wci_unexpected_dva");
                return;
            end
            e = (sel == 0) ? wci_q0.pop_front() : wci_q1.pop_front();
            $display("WCI dut%0d resp sdata %h expected %h", sel, sdata, e);
            check("wci_sdata", {224'd0, sdata}, {224'd0, e});
        end
    endtask

    initial begin
        nwords[0] = 0;
        nwords[1] = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (u_wsi32.MCmd == 3'b001)
                    wsi_check(0, {224'd0, u_wsi32.MData}, {28'd0, u_wsi32.MByteEn},
                              u_wsi32.MReqLast, u_wsi32.MBurstLength, u_wsi32.MReqInfo);
                if (u_wsi128.MCmd == 3'b001)
                    wsi_check(1, {128'd0, u_wsi128.MData}, {16'd0, u_wsi128.MByteEn},
                              u_wsi128.MReqLast, u_wsi128.MBurstLength, u_wsi128.MReqInfo);
                wci_check(0, u_wci32.SResp, u_wci32.SData, pend0);
                wci_check(1, u_wci128.SResp, u_wci128.SData, pend1);
            end
            pend0 = rst_n && (u_wci32.MCmd == 3'b001 || u_wci32.MCmd == 3'b010);
            pend1 = rst_n && (u_wci128.MCmd == 3'b001 || u_wci128.MCmd == 3'b010);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wci_req(input int sel, input logic [2:0] cmd, input logic space,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input logic [31:0] exp);
        @(posedge clk); #1;
        if (sel == 0) begin
            u_wci32.MCmd = cmd; u_wci32.MAddrSpace = space; u_wci32.MAddr = addr;
            u_wci32.MData = data; u_wci32.MByteEn = be;
            wci_q0.push_back(exp);
        end else begin
            u_wci128.MCmd = cmd; u_wci128.MAddrSpace = space; u_wci128.MAddr = addr;
            u_wci128.MData = data; u_wci128.MByteEn = be;
            wci_q1.push_back(exp);
        end
        @(posedge clk); #1;
        u_wci32.MCmd = 3'b000;
        u_wci128.MCmd = 3'b000;
    endtask

    task automatic cfg_wr(input int sel, input logic [31:0] addr, input logic [31:0] data);
        wci_req(sel, 3'b001, 1'b1, addr, data, 4'hF, 32'd0);
    endtask

    task automatic cfg_rd(input int sel, input logic [31:0] addr, input logic [31:0] exp);
        wci_req(sel, 3'b010, 1'b1, addr, 32'd0, 4'hF, exp);
    endtask

    task automatic ctl_op(input int sel, input logic [2:0] op);
        wci_req(sel, 3'b010, 1'b0, {27'd0, op, 2'b00}, 32'd0, 4'hF, 32'd0);
    endtask

    // Expected 32-bit-wide stream: pattern continues across messages.
    task automatic push_seq32(input logic [31:0] seed, input int len, input int count, input logic [7:0] op);
        logic [31:0] ctr = seed;
        exp_word_t e;
        for (int m = 0; m < count; m++) begin
            for (int w = 0; w < ((len == 0) ? 1 : len); w++) begin
                e.data = {224'd0, ctr};
                e.be   = (len == 0) ? 32'h0 : 32'hF;
                e.last = (len == 0) || (w == len - 1);
                e.blen = (len == 0) ? 12'd1 : 12'(len);
                e.info = op;
                wsi_q0.push_back(e);
                if (len != 0) ctr = ctr + 32'd1;
            end
        end
    endtask

    task automatic wait_drain(input int sel);
        int i = 0;
        while (((sel == 0) ? wsi_q0.size() : wsi_q1.size()) != 0 && i < 3000) begin
            @(posedge clk);
            i++;
        end
        if (((sel == 0) ? wsi_q0.size() : wsi_q1.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words pending expected 0",
                     (sel == 0) ? wsi_q0.size() : wsi_q1.size());
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        exp_word_t e;
        int base;
        int i;
        u_wci32.MCmd = 3'b000; u_wci32.MAddrSpace = 1'b0; u_wci32.MByteEn = 4'h0;
        u_wci32.MAddr = 32'd0; u_wci32.MData = 32'd0; u_wci32.MFlag = 2'b00;
        u_wci128.MCmd = 3'b000; u_wci128.MAddrSpace = 1'b0; u_wci128.MByteEn = 4'h0;
        u_wci128.MAddr = 32'd0; u_wci128.MData = 32'd0; u_wci128.MFlag = 2'b00;

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_sthreadbusy", {255'd0, u_wci32.SThreadBusy}, 256'd1);
        check("rst_wsi_mreset_n", {255'd0, u_wsi32.MReset_n}, 256'd0);
        check("rst_wsi_mcmd", {253'd0, u_wsi32.MCmd}, 256'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_sthreadbusy", {255'd0, u_wci32.SThreadBusy}, 256'd0);
        check("idle_wsi_mreset_n", {255'd0, u_wsi32.MReset_n}, 256'd1);
        check("idle_wsi_mcmd", {253'd0, u_wsi32.MCmd}, 256'd0);
        check("idle_mreqlast", {255'd0, u_wsi32.MReqLast}, 256'd0);
        check("idle_burstprecise", {255'd0, u_wsi32.MBurstPrecise}, 256'd1);
        check("idle_mburstlen", {244'd0, u_wsi32.MBurstLength}, 256'd0);
        check("idle_sresp", {254'd0, u_wci32.SResp}, 256'd0);
        check("idle_sflag", {254'd0, u_wci32.SFlag}, 256'd0);
        cfg_rd(0, 32'h00, 32'd0);

        // Two 4-word messages
        cfg_wr(0, 32'h04, 32'd4);
        cfg_wr(0, 32'h08, 32'd2);
        cfg_wr(0, 32'h0C, 32'h10);
        cfg_wr(0, 32'h10, 32'h05);
        cfg_rd(0, 32'h04, 32'd4);
        push_seq32(32'h10, 4, 2, 8'h05);
        ctl_op(0, 3'd1);
        wait_drain(0);
        cfg_rd(0, 32'h14, 32'd8);
        cfg_rd(0, 32'h18, 32'd2);
        cfg_rd(0, 32'h00, 32'd1);
        // Raising msgCount in DONE must not restart issue
        cfg_wr(0, 32'h08, 32'd3);
        repeat (20) @(posedge clk);
        ctl_op(0, 3'd2);
        ctl_op(0, 3'd0);
        cfg_rd(0, 32'h14, 32'd0);

        // Same traffic under backpressure and a downstream reset pulse
        cfg_wr(0, 32'h08, 32'd2);
        push_seq32(32'h10, 4, 2, 8'h05);
        ctl_op(0, 3'd1);
        repeat (2) @(posedge clk);
        #1 busy = 1'b1;
        repeat (4) @(posedge clk);
        #1 busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 sreset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 sreset_n = 1'b1;
        wait_drain(0);
        cfg_rd(0, 32'h14, 32'd8);
        cfg_rd(0, 32'h18, 32'd2);
        ctl_op(0, 3'd2);
        ctl_op(0, 3'd0);

        // Zero-length messages
        cfg_wr(0, 32'h04, 32'd0);
        cfg_wr(0, 32'h08, 32'd3);
        push_seq32(32'h10, 0, 3, 8'h05);
        ctl_op(0, 3'd1);
        wait_drain(0);
        cfg_rd(0, 32'h14, 32'd3);
        cfg_rd(0, 32'h18, 32'd3);
        ctl_op(0, 3'd2);
        ctl_op(0, 3'd0);

        // Masked writes, unmapped reads, unknown control op
        cfg_wr(0, 32'h0C, 32'hFFFF0100);
        wci_req(0, 3'b001, 1'b1, 32'h0C, 32'h00000000, 4'b1100, 32'd0);
        cfg_rd(0, 32'h0C, 32'h00000100);
        cfg_rd(0, 32'h1C, 32'd0);
        cfg_rd(0, 32'h20, 32'd0);
        ctl_op(0, 3'd5);
        cfg_rd(0, 32'h00, 32'd0);

        // Infinite count, stop during the message: message still completes
        cfg_wr(0, 32'h04, 32'd4);
        cfg_wr(0, 32'h08, 32'd0);
        cfg_wr(0, 32'h10, 32'h22);
        push_seq32(32'h100, 4, 1, 8'h22);
        base = nwords[0];
        ctl_op(0, 3'd1);
        i = 0;
        while (nwords[0] < base + 1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        ctl_op(0, 3'd2);
        wait_drain(0);
        repeat (20) @(posedge clk);
        cfg_rd(0, 32'h18, 32'd1);
        cfg_rd(0, 32'h14, 32'd4);

        // 128-bit instance: lane wrap across 2^32
        cfg_wr(1, 32'h04, 32'd2);
        cfg_wr(1, 32'h08, 32'd1);
        cfg_wr(1, 32'h0C, 32'hFFFFFFFE);
        e.data = {128'd0, 128'h00000001_00000000_FFFFFFFF_FFFFFFFE};
        e.be = 32'hFFFF; e.last = 1'b0; e.blen = 12'd2; e.info = 8'h00;
        wsi_q1.push_back(e);
        e.data = {128'd0, 128'h00000005_00000004_00000003_00000002};
        e.last = 1'b1;
        wsi_q1.push_back(e);
        ctl_op(1, 3'd1);
        wait_drain(1);
        cfg_rd(1, 32'h14, 32'd2);
        cfg_rd(1, 32'h18, 32'd1);

        repeat (5) @(posedge clk);
        if (wci_q0.size() != 0 || wci_q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wci_missing_dva: got %0d pending expected 0", wci_q0.size() + wci_q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
